// File: rtl/lm32_dp_ram_ctrl_pkg.sv
// Shared definitions for the dual-port RAM write-port controller.
//   state_e : controller state. The encoding matches the shared lm32
//             defines: FLUSH = 1'b0, IDLE = 1'b1.
//   pick_b  : round-robin choice between the two write requesters.
package lm32_dp_ram_ctrl_pkg;

   typedef enum logic {
      ST_FLUSH = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   // B wins when it is the only requester. On contention it wins only if
   // A took the previous grant (last_b == 0).
   function automatic logic pick_b(input logic a_req, input logic b_req,
                                   input logic last_b);
      return b_req & (~a_req | ~last_b);
   endfunction

endpackage

// File: rtl/lm32_dp_ram_ctrl.sv
// Write-port controller for the simple dual-port RAM behind the cache
// tag/data arrays. After reset, or when flush_i is asserted, it sweeps every
// word to init_value. After that it shares the single write port between
// requesters A and B with round-robin arbitration.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   flush_i                   request a full-array flush (level)
//   a_req_i/a_addr_i/a_data_i requester A write request, address, data
//   a_gnt_o                   A's write is performed this cycle
//   b_*                       same for requester B
//   ram_we_o/ram_waddr_o/ram_wdata_o  RAM write port
//   busy_o                    flush in progress, RAM contents invalid
//   flush_done_o              one-cycle pulse in the first IDLE cycle
module lm32_dp_ram_ctrl #(
   parameter int                    addr_width = 32,
   parameter int                    addr_depth = 1024,
   parameter int                    data_width = 8,
   parameter logic [data_width-1:0] init_value = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  a_req_i,
   input  logic [addr_width-1:0] a_addr_i,
   input  logic [data_width-1:0] a_data_i,
   output logic                  a_gnt_o,
   input  logic                  b_req_i,
   input  logic [addr_width-1:0] b_addr_i,
   input  logic [data_width-1:0] b_data_i,
   output logic                  b_gnt_o,
   output logic                  ram_we_o,
   output logic [addr_width-1:0] ram_waddr_o,
   output logic [data_width-1:0] ram_wdata_o,
   output logic                  busy_o,
   output logic                  flush_done_o
);
   import lm32_dp_ram_ctrl_pkg::*;

   localparam logic [addr_width-1:0] last_addr = addr_width'(addr_depth - 1);

   state_e                state_q, state_d;
   logic [addr_width-1:0] cnt_q, cnt_d;
   logic                  last_b_q, last_b_d;
   logic                  done_q, done_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_FLUSH;
         cnt_q    <= '0;
         last_b_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_b_q <= last_b_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_b_d    = last_b_q;
      done_d      = 1'b0;
      a_gnt_o     = 1'b0;
      b_gnt_o     = 1'b0;
      ram_we_o    = 1'b0;
      ram_waddr_o = '0;
      ram_wdata_o = '0;
      busy_o      = 1'b0;

      case (state_q)
         ST_FLUSH: begin
            // Requests stay pending; the requesters keep them asserted.
            ram_we_o    = 1'b1;
            ram_waddr_o = cnt_q;
            ram_wdata_o = init_value;
            busy_o      = 1'b1;
            if (flush_i) begin
               // Restart takes priority over finishing, so no done pulse.
               cnt_d = '0;
            end else if (cnt_q == last_addr) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + addr_width'(1);
            end
         end

         default: begin
            // Grants never depend on flush_i. A flush request still lets
            // this cycle's write through and starts on the next cycle.
            b_gnt_o = pick_b(a_req_i, b_req_i, last_b_q);
            a_gnt_o = a_req_i & ~b_gnt_o;
            if (a_gnt_o) begin
               ram_we_o    = 1'b1;
               ram_waddr_o = a_addr_i;
               ram_wdata_o = a_data_i;
               last_b_d    = 1'b0;
            end else if (b_gnt_o) begin
               ram_we_o    = 1'b1;
               ram_waddr_o = b_addr_i;
               ram_wdata_o = b_data_i;
               last_b_d    = 1'b1;
            end
            if (flush_i) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
      endcase
   end

   assign flush_done_o = done_q;

endmodule

// File: tb/tb_lm32_dp_ram_ctrl.sv
module tb_lm32_dp_ram_ctrl;
   localparam int         AW    = 32;
   localparam int         DEPTH = 16;
   localparam logic [7:0] INIT  = 8'hA5;

   logic          clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic          a_req = 1'b0, b_req = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [7:0]    a_data = '0, b_data = '0;
   logic          a_gnt, b_gnt, ram_we, busy, done;
   logic [AW-1:0] ram_waddr;
   logic [7:0]    ram_wdata;

   lm32_dp_ram_ctrl #(.addr_width(AW), .addr_depth(DEPTH), .data_width(8),
                      .init_value(INIT)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .a_req_i(a_req), .a_addr_i(a_addr), .a_data_i(a_data), .a_gnt_o(a_gnt),
      .b_req_i(b_req), .b_addr_i(b_addr), .b_data_i(b_data), .b_gnt_o(b_gnt),
      .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
      .busy_o(busy), .flush_done_o(done));

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   // Stand-in for the RAM attached to the write port.
   logic [7:0] ram [DEPTH];
   always @(posedge clk)
      if (ram_we && ram_waddr < DEPTH) ram[ram_waddr[3:0]] <= ram_wdata;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", n, act, exp);
      end
   endtask

   // Reference model: the array is either being swept (position m_pos) or
   // open for writes. m_a_turn says whether A wins the next tie.
   bit m_sweep, m_a_turn, m_done;
   int m_pos;

   task automatic m_reset();
      m_sweep = 1; m_pos = 0; m_a_turn = 1; m_done = 0;
   endtask

   task automatic m_grants(output bit ga, output bit gb);
      ga = 0; gb = 0;
      if (!m_sweep) begin
         if (a_req && b_req) begin ga = m_a_turn; gb = !m_a_turn; end
         else begin ga = a_req; gb = b_req; end
      end
   endtask

   task automatic check_all(input string tag);
      bit ga, gb, we;
      logic [AW-1:0] wa;
      logic [7:0] wd;
      m_grants(ga, gb);
      we = m_sweep || ga || gb;
      wa = m_sweep ? AW'(m_pos) : ga ? a_addr : gb ? b_addr : '0;
      wd = m_sweep ? INIT : ga ? a_data : gb ? b_data : 8'h00;
      chk({tag, ".a_gnt"}, a_gnt, ga);
      chk({tag, ".b_gnt"}, b_gnt, gb);
      chk({tag, ".we"}, ram_we, we);
      chk({tag, ".waddr"}, ram_waddr, wa);
      chk({tag, ".wdata"}, ram_wdata, wd);
      chk({tag, ".busy"}, busy, m_sweep);
      chk({tag, ".done"}, done, m_done);
   endtask

   task automatic m_advance();
      bit ga, gb;
      m_grants(ga, gb);
      m_done = 0;
      if (m_sweep) begin
         if (flush) m_pos = 0;
         else if (m_pos == DEPTH - 1) begin m_sweep = 0; m_pos = 0; m_done = 1; end
         else m_pos++;
      end else begin
         if (ga) m_a_turn = 0;
         if (gb) m_a_turn = 1;
         if (flush) begin m_sweep = 1; m_pos = 0; end
      end
   endtask

   // Each cycle: inputs are driven at posedge+1, checked at posedge+5.
   task automatic half(input string tag);
      #4;
      check_all(tag);
   endtask

   task automatic tick();
      m_advance();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic fl, ar; logic [AW-1:0] aa; logic [7:0] ad;
      logic br; logic [AW-1:0] ba; logic [7:0] bd;
      logic eag, ebg, ewe; logic [AW-1:0] ewa; logic [7:0] ewd; logic ebusy, edone;
   } vec_t;
   vec_t tbl [10];

   bit ag_seen, bg_seen;
   int n;

   initial begin
      //         fl ar aa ad     br ba bd     ag bg we wa  wd     busy done
      tbl[0] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1};
      tbl[1] = '{0, 1, 3, 8'h11, 0, 0, 8'h00, 1, 0, 1, 3, 8'h11, 0, 0};
      tbl[2] = '{0, 0, 0, 8'h00, 1, 7, 8'h22, 0, 1, 1, 7, 8'h22, 0, 0};
      tbl[3] = '{0, 1, 5, 8'h33, 1, 6, 8'h44, 1, 0, 1, 5, 8'h33, 0, 0};
      tbl[4] = '{0, 1, 5, 8'h33, 1, 6, 8'h44, 0, 1, 1, 6, 8'h44, 0, 0};
      tbl[5] = '{0, 1, 5, 8'h33, 1, 6, 8'h44, 1, 0, 1, 5, 8'h33, 0, 0};
      tbl[6] = '{0, 1, 5, 8'h33, 1, 6, 8'h44, 0, 1, 1, 6, 8'h44, 0, 0};
      tbl[7] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[8] = '{1, 1, 9, 8'h55, 0, 0, 8'h00, 1, 0, 1, 9, 8'h55, 0, 0};
      tbl[9] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, INIT,  1, 0};

      // Reset held: the outputs show the first flush write.
      m_reset();
      #3;
      chk("rst.we", ram_we, 1); chk("rst.waddr", ram_waddr, 0);
      chk("rst.wdata", ram_wdata, INIT); chk("rst.busy", busy, 1);
      chk("rst.gnt", {a_gnt, b_gnt}, 0); chk("rst.done", done, 0);
      @(posedge clk); #1; rst = 0;

      // Initial sweep: addresses 0..DEPTH-1 with INIT.
      for (int i = 0; i < DEPTH; i++) begin
         half("sweep");
         chk("sweep.addr", ram_waddr, i);
         tick();
      end
      for (int i = 0; i < DEPTH; i++) chk("ram_init", ram[i], INIT);

      // Table: done cycle, single and contended grants, flush from IDLE.
      for (int i = 0; i < 10; i++) begin
         flush = tbl[i].fl; a_req = tbl[i].ar; a_addr = tbl[i].aa; a_data = tbl[i].ad;
         b_req = tbl[i].br; b_addr = tbl[i].ba; b_data = tbl[i].bd;
         half($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.gnt", i), {a_gnt, b_gnt}, {tbl[i].eag, tbl[i].ebg});
         chk($sformatf("vec%0d.we", i), ram_we, tbl[i].ewe);
         chk($sformatf("vec%0d.waddr", i), ram_waddr, tbl[i].ewa);
         chk($sformatf("vec%0d.wdata", i), ram_wdata, tbl[i].ewd);
         chk($sformatf("vec%0d.busy_done", i), {busy, done}, {tbl[i].ebusy, tbl[i].edone});
         tick();
      end

      // B waits through the rest of the sweep, then wins in the first IDLE cycle.
      b_req = 1; b_addr = 'hC; b_data = 8'h77;
      for (int i = 1; i < DEPTH; i++) begin
         half("bwait");
         chk("bwait.gnt", b_gnt, 0);
         tick();
      end
      half("bgnt");
      chk("bgnt.gnt", b_gnt, 1); chk("bgnt.addr", ram_waddr, 'hC);
      chk("bgnt.data", ram_wdata, 8'h77); chk("bgnt.done", done, 1);
      tick();
      b_req = 0;

      // Restart the sweep when it is at address 9.
      flush = 1; half("fl_go"); tick(); flush = 0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         flush = (i == 9);
         half("rf");
         if (busy && ram_we) n++;
         tick();
      end
      flush = 0;
      half("rf0");
      chk("restart.addr", ram_waddr, 0); chk("restart.busy", busy, 1);
      for (int i = 0; i < 40 && busy; i++) begin
         if (ram_we) n++;
         tick();
         half("rf");
      end
      chk("restart.len", n, 10 + DEPTH);
      chk("restart.done", done, 1);
      tick();

      // Reset in the middle of a sweep.
      flush = 1; half("r1"); tick(); flush = 0;
      for (int i = 0; i < 5; i++) begin half("r1"); tick(); end
      #2; rst = 1; #1;
      chk("rstmid.addr", ram_waddr, 0); chk("rstmid.busy", busy, 1);
      chk("rstmid.we", ram_we, 1);
      m_reset();
      @(posedge clk); #1; rst = 0;
      half("rstmid0"); chk("rstmid0.addr", ram_waddr, 0); tick();
      for (int i = 1; i <= DEPTH; i++) begin half("r1b"); tick(); end

      // Reset while a grant is being issued.
      a_req = 1; a_addr = 4; a_data = 8'h66;
      half("rg"); chk("rg.gnt", a_gnt, 1);
      #1; rst = 1; #1;
      chk("rstgnt.gnt", a_gnt, 0); chk("rstgnt.wdata", ram_wdata, INIT);
      chk("rstgnt.busy_done", {busy, done}, 2'b10);
      a_req = 0; m_reset();
      @(posedge clk); #1; rst = 0;
      for (int i = 0; i <= DEPTH; i++) begin half("r2"); tick(); end

      // Random traffic; requesters hold their request until granted.
      ag_seen = 0; bg_seen = 0;
      for (int c = 0; c < 600; c++) begin
         if (!a_req || ag_seen) begin
            a_req = ($urandom_range(0, 2) != 0);
            a_addr = AW'($urandom_range(0, DEPTH - 1)); a_data = 8'($urandom);
         end
         if (!b_req || bg_seen) begin
            b_req = ($urandom_range(0, 2) != 0);
            b_addr = AW'($urandom_range(0, DEPTH - 1)); b_data = 8'($urandom);
         end
         flush = ($urandom_range(0, 39) == 0);
         half("rnd");
         ag_seen = a_gnt; bg_seen = b_gnt;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, bad=%0d", bad);
      $fatal(1);
   end
endmodule
